// File: rtl/cardinal_mem_arbiter.sv
// Serialises the four cardinal_processor dmem ports onto one single-ported synchronous memory.
// Define CARDINAL_ARB_RR_EN for round-robin priority; otherwise node0 has fixed highest priority.
module cardinal_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:3]            req,
  input  logic [0:3]            req_wr,
  input  logic [0:4*ADDR_W-1]   req_addr,
  input  logic [0:4*DATA_W-1]   req_wdata,
  output logic [0:3]            ack,
  output logic [0:DATA_W-1]     rdata,
  output logic                  mem_en,
  output logic                  mem_wr_en,
  output logic [0:ADDR_W-1]     mem_addr,
  output logic [0:DATA_W-1]     mem_wdata,
  input  logic [0:DATA_W-1]     mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;

  state_e              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [1:0]          gnt_q, gnt_d;
  logic                wr_q, wr_d;
  logic [0:3]          ack_q, ack_d;
  logic [0:DATA_W-1]   rdata_q, rdata_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_wr_en_q, mem_wr_en_d;
  logic [0:ADDR_W-1]   mem_addr_q, mem_addr_d;
  logic [0:DATA_W-1]   mem_wdata_q, mem_wdata_d;
  logic [1:0]          pick;
  logic                found;

  // First requester at or after ptr, wrapping 3 -> 0; ptr stays 0 in the fixed-priority build.
  always_comb begin
    pick  = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && req[ptr_q + 2'(i)]) begin
        pick  = ptr_q + 2'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    wr_d        = wr_q;
    ack_d       = '0;
    rdata_d     = '0;
    mem_en_d    = 1'b0;
    mem_wr_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d       = pick;
          wr_d        = req_wr[pick];
          mem_en_d    = 1'b1;
          mem_wr_en_d = req_wr[pick];
          mem_addr_d  = req_addr[int'(pick)*ADDR_W +: ADDR_W];
          mem_wdata_d = req_wdata[int'(pick)*DATA_W +: DATA_W];
          state_d     = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        rdata_d       = wr_q ? '0 : mem_rdata;
        ack_d[gnt_q]  = 1'b1;
        state_d       = ACK;
      end
      ACK: begin
`ifdef CARDINAL_ARB_RR_EN
        ptr_d = gnt_q + 2'd1;
`endif
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      gnt_q       <= 2'd0;
      wr_q        <= 1'b0;
      ack_q       <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      wr_q        <= wr_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
